// File: rtl/cache_maint_sequencer.sv
// Cache maintenance sequencer: runs FENCE.I / D-flush / I-clear / full writeback-invalidate
// sequences against the L1 control handshakes, with a per-phase watchdog.
module cache_maint_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned CNT_W          = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       req_valid,
   input  logic [1:0] req_op,
   output logic       req_ready,
   output logic       resp_valid,
   output logic       resp_error,
   output logic       busy,
   output logic       dcache_flush,
   output logic       dcache_clear,
   output logic       icache_clear,
   input  logic       dflush_done,
   input  logic       dclear_done,
   input  logic       iclear_done
);

   typedef enum logic [2:0] {
      StIdle,
      StDFlush,
      StDClear,
      StIClear,
      StResp
   } state_e;

   localparam logic [1:0] OpFenceI = 2'd0;
   localparam logic [1:0] OpDFlush = 2'd1;
   localparam logic [1:0] OpIClear = 2'd2;
   localparam logic [1:0] OpFull   = 2'd3;

   localparam bit             WdogEn  = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0] CntLast = WdogEn ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
   localparam logic [CNT_W-1:0] CntMax  = '1;

   state_e           state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             phase_done;
   logic             timeout;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= StIdle;
         op_q    <= 2'd0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // Only the done belonging to the current phase is ever looked at.
   always_comb begin
      phase_done = 1'b0;
      unique case (state_q)
         StDFlush: phase_done = dflush_done;
         StDClear: phase_done = dclear_done;
         StIClear: phase_done = iclear_done;
         default:  phase_done = 1'b0;
      endcase
   end

   assign timeout = WdogEn && !phase_done && (cnt_q == CntLast);

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               op_d    = req_op;
               cnt_d   = '0;
               err_d   = 1'b0;
               state_d = (req_op == OpIClear) ? StIClear : StDFlush;
            end
         end
         StDFlush, StDClear, StIClear: begin
            if (phase_done) begin
               cnt_d = '0;
               if (state_q == StDFlush) begin
                  unique case (op_q)
                     OpFenceI: state_d = StIClear;
                     OpFull:   state_d = StDClear;
                     OpDFlush: state_d = StResp;
                     default:  state_d = StResp;
                  endcase
               end else if (state_q == StDClear) begin
                  state_d = StIClear;
               end else begin
                  state_d = StResp;
               end
            end else if (timeout) begin
               // Abandon the rest of the sequence and report the failure.
               state_d = StResp;
               err_d   = 1'b1;
            end else if (cnt_q != CntMax) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StResp: begin
            state_d = StIdle;
            err_d   = 1'b0;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      req_ready    = (state_q == StIdle);
      busy         = (state_q != StIdle);
      resp_valid   = (state_q == StResp);
      resp_error   = (state_q == StResp) && err_q;
      dcache_flush = (state_q == StDFlush);
      dcache_clear = (state_q == StDClear);
      icache_clear = (state_q == StIClear);
   end

endmodule

// File: tb/tb_cache_maint_sequencer.sv
// Randomised bench for cache_maint_sequencer: a phase-list model builds the expected per-cycle
// output trace and the done stimulus together; a compare process checks every cycle.
module tb_cache_maint_sequencer;

   localparam int TO = 8;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       req_valid = 1'b0;
   logic [1:0] req_op = 2'd0;
   logic       req_ready, resp_valid, resp_error, busy;
   logic       dcache_flush, dcache_clear, icache_clear;
   logic       dflush_done = 1'b0, dclear_done = 1'b0, iclear_done = 1'b0;

   cache_maint_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .req_valid    (req_valid),
      .req_op       (req_op),
      .req_ready    (req_ready),
      .resp_valid   (resp_valid),
      .resp_error   (resp_error),
      .busy         (busy),
      .dcache_flush (dcache_flush),
      .dcache_clear (dcache_clear),
      .icache_clear (icache_clear),
      .dflush_done  (dflush_done),
      .dclear_done  (dclear_done),
      .iclear_done  (iclear_done)
   );

   always #5 CLK = ~CLK;

   // One entry per clock cycle: inputs held during the cycle, outputs expected in it.
   typedef struct {
      bit       rst;
      bit       rv;
      bit [1:0] op;
      bit       fd, cd, id;
      bit       e_fl, e_cl, e_ic, e_rv, e_re, e_busy, e_rdy;
   } cyc_t;

   cyc_t plan[$];
   cyc_t cur;
   bit   chk_en = 1'b0;
   int   cyc_no = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic act, input bit exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %b expected %b", name, cyc_no, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic cyc_t idle_cyc(input bit rst, input bit rv, input bit [1:0] op);
      cyc_t c;
      c.rst = rst; c.rv = rv; c.op = op;
      c.fd = 1'($urandom_range(1, 0));
      c.cd = 1'($urandom_range(1, 0));
      c.id = 1'($urandom_range(1, 0));
      c.e_fl = 0; c.e_cl = 0; c.e_ic = 0; c.e_rv = 0; c.e_re = 0; c.e_busy = 0;
      c.e_rdy = 1;
      return c;
   endfunction

   task automatic add_idle(input int n);
      for (int i = 0; i < n; i++) plan.push_back(idle_cyc(0, 0, 2'($urandom_range(3, 0))));
   endtask

   task automatic add_rst(input int n);
      for (int i = 0; i < n; i++) plan.push_back(idle_cyc(1, 1'($urandom_range(1, 0)), 2'd0));
   endtask

   // Phase codes: 0 = D-flush, 1 = D-clear, 2 = I-clear. lat = phase cycle whose done is high,
   // 0 = never. resp_off = cycles from acceptance edge to the resp_valid cycle.
   task automatic add_txn(input bit [1:0] op, input int l0, input int l1, input int l2,
                          input bit hold, input bit [1:0] hold_op,
                          output int resp_off, output bit err);
      int   ph[$];
      int   lat[3];
      int   len;
      bit   abandon;
      cyc_t c;
      lat[0] = l0; lat[1] = l1; lat[2] = l2;
      case (op)
         2'd0:    ph = '{0, 2};
         2'd1:    ph = '{0};
         2'd2:    ph = '{2};
         default: ph = '{0, 1, 2};
      endcase
      plan.push_back(idle_cyc(0, 1, op));
      resp_off = 0;
      err = 0;
      for (int i = 0; i < ph.size(); i++) begin
         abandon = !(lat[i] != 0 && lat[i] <= TO);
         len = abandon ? TO : lat[i];
         for (int k = 1; k <= len; k++) begin
            c = idle_cyc(0, hold ? 1'b1 : 1'($urandom_range(1, 0)),
                         hold ? hold_op : 2'($urandom_range(3, 0)));
            c.e_rdy = 0; c.e_busy = 1;
            case (ph[i])
               0: begin c.e_fl = 1; c.fd = (k == lat[i]); end
               1: begin c.e_cl = 1; c.cd = (k == lat[i]); end
               default: begin c.e_ic = 1; c.id = (k == lat[i]); end
            endcase
            plan.push_back(c);
         end
         resp_off += len;
         if (abandon) begin
            err = 1;
            break;
         end
      end
      c = idle_cyc(0, hold ? 1'b1 : 1'($urandom_range(1, 0)),
                   hold ? hold_op : 2'($urandom_range(3, 0)));
      c.e_rdy = 0; c.e_busy = 1; c.e_rv = 1; c.e_re = err;
      plan.push_back(c);
      resp_off += 1;
   endtask

   initial begin
      forever begin
         @(negedge CLK);
         #2;
         if (chk_en) begin
            check("req_ready", req_ready, cur.e_rdy);
            check("busy", busy, cur.e_busy);
            check("resp_valid", resp_valid, cur.e_rv);
            check("resp_error", resp_error, cur.e_re);
            check("dcache_flush", dcache_flush, cur.e_fl);
            check("dcache_clear", dcache_clear, cur.e_cl);
            check("icache_clear", icache_clear, cur.e_ic);
         end
      end
   end

   initial begin
      int off;
      bit err;
      int keep;

      add_rst(2);
      add_idle(1);

      // Reset in the middle of a FENCE_I while the D-flush is pending.
      keep = plan.size() + 4;
      add_txn(2'd0, 0, 0, 0, 0, 2'd0, off, err);
      while (plan.size() > keep) void'(plan.pop_back());
      add_rst(3);
      add_idle(1);

      add_txn(2'd0, 5, 2, 0, 0, 2'd0, off, err);
      check_int("fencei_resp_offset", off, 8);
      check_int("fencei_error", int'(err), 0);

      add_txn(2'd3, 1, 1, 1, 0, 2'd0, off, err);
      check_int("full_min_resp_offset", off, 4);

      add_idle(1);
      add_txn(2'd3, 0, 0, 0, 0, 2'd0, off, err);
      check_int("timeout_resp_offset", off, TO + 1);
      check_int("timeout_error", int'(err), 1);
      add_txn(2'd2, 1, 0, 0, 0, 2'd0, off, err);
      check_int("iclear_after_timeout_offset", off, 2);

      // Stale iclear_done during D-flush is random; I-clear answers in its third cycle.
      add_txn(2'd0, 2, 3, 0, 0, 2'd0, off, err);

      // Back-pressure: ICLEAR held while a DFLUSH runs, then done on the timeout cycle.
      add_txn(2'd1, 3, 0, 0, 1, 2'd2, off, err);
      add_txn(2'd2, TO, 0, 0, 0, 2'd0, off, err);
      check_int("done_beats_timeout_error", int'(err), 0);

      for (int n = 0; n < 40; n++) begin
         add_idle($urandom_range(2, 0));
         add_txn(2'($urandom_range(3, 0)), $urandom_range(10, 0), $urandom_range(10, 0),
                 $urandom_range(10, 0), 1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)),
                 off, err);
      end
      add_idle(2);

      foreach (plan[i]) begin
         @(negedge CLK);
         RST         = plan[i].rst;
         req_valid   = plan[i].rv;
         req_op      = plan[i].op;
         dflush_done = plan[i].fd;
         dclear_done = plan[i].cd;
         iclear_done = plan[i].id;
         cur         = plan[i];
         cyc_no      = i;
         chk_en      = 1'b1;
      end
      @(negedge CLK);
      chk_en = 1'b0;
      #5;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
